// File: rtl/branch_resolve.sv
// Branch condition evaluation with registered taken pulse and target, plus a wrong-path shadow.
// Optional BRANCH_RESOLVE_STATS_EN adds saturating evaluated/taken branch counters.
module branch_resolve #(
    parameter int XLEN       = 64,
    parameter int SHADOW_LEN = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic            ex_branch,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    output logic            branch,
    output logic [XLEN-1:0] target_pc,
    output logic            in_shadow
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    output logic [15:0]     br_count,
    output logic [15:0]     taken_count
`endif
);

    typedef enum logic {
        IDLE   = 1'b0,
        SHADOW = 1'b1
    } state_t;

    state_t                 state, state_nxt;
    logic [1:0]             cnt, cnt_nxt;
    logic                   eval, taken;
    logic signed [XLEN-1:0] rs1_s, rs2_s;
    logic                   branch_p1;
    logic [XLEN-1:0]        target_pc_p1;

    assign rs1_s = rs1_data;
    assign rs2_s = rs2_data;

    function automatic logic cond_taken(input logic [2:0] f3,
                                        input logic signed [XLEN-1:0] a,
                                        input logic signed [XLEN-1:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return a < b;
            3'b101:  return a >= b;
            3'b110:  return $unsigned(a) < $unsigned(b);
            3'b111:  return $unsigned(a) >= $unsigned(b);
            default: return 1'b0;
        endcase
    endfunction

    // Shadow counter holds the remaining wrong-path cycles; leaving on 1 keeps it 0 in IDLE.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        eval      = ex_valid && ex_branch && (state == IDLE);
        taken     = eval && cond_taken(funct3, rs1_s, rs2_s);
        case (state)
            IDLE: begin
                if (taken) begin
                    state_nxt = SHADOW;
                    cnt_nxt   = 2'(SHADOW_LEN);
                end
            end
            SHADOW: begin
                if (cnt == 2'd1) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 2'd0;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 2'd0;
            end
        endcase
    end

    // Stage p1: registered pulse and target; target holds between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 2'd0;
            branch_p1    <= 1'b0;
            target_pc_p1 <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            branch_p1 <= taken;
            if (taken) begin
                target_pc_p1 <= pc + imm;
            end
        end
    end

    assign branch    = branch_p1;
    assign target_pc = target_pc_p1;
    assign in_shadow = (state == SHADOW);

`ifdef BRANCH_RESOLVE_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] br_count_p1, taken_count_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            br_count_p1    <= 16'd0;
            taken_count_p1 <= 16'd0;
        end else begin
            if (eval) begin
                br_count_p1 <= sat_inc(br_count_p1);
            end
            if (taken) begin
                taken_count_p1 <= sat_inc(taken_count_p1);
            end
        end
    end

    assign br_count    = br_count_p1;
    assign taken_count = taken_count_p1;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: cycle-level reference model plus literal spot checks.
module tb_branch_resolve;
    localparam int XLEN = 64;
    localparam int SL   = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            ex_valid, ex_branch;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data, rs2_data, pc, imm;
    logic            branch, in_shadow;
    logic [XLEN-1:0] target_pc;
`ifdef BRANCH_RESOLVE_STATS_EN
    logic [15:0]     br_count, taken_count;
`endif

    branch_resolve #(.XLEN(XLEN), .SHADOW_LEN(SL)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_branch(ex_branch),
        .funct3(funct3), .rs1_data(rs1_data), .rs2_data(rs2_data), .pc(pc), .imm(imm),
        .branch(branch), .target_pc(target_pc), .in_shadow(in_shadow)
`ifdef BRANCH_RESOLVE_STATS_EN
        , .br_count(br_count), .taken_count(taken_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a taken evaluation at cycle c blocks evaluation until cycle c+SL+1.
    function automatic bit ref_taken(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [XLEN-1:0] flip;
        flip = {1'b1, {(XLEN-1){1'b0}}};
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return (a ^ flip) < (b ^ flip);
            3'b101:  return !((a ^ flip) < (b ^ flip));
            3'b110:  return a < b;
            3'b111:  return !(a < b);
            default: return 1'b0;
        endcase
    endfunction

    longint          cyc = 0;
    longint          free_at = 0;
    bit              exp_branch = 0, exp_shadow = 0;
    logic [XLEN-1:0] exp_target = '0;
    int              exp_br = 0, exp_tk = 0;

    always @(posedge clk) begin
        if (reset) begin
            exp_branch = 0;
            exp_target = '0;
            free_at    = cyc + 1;
            exp_br     = 0;
            exp_tk     = 0;
        end else begin
            exp_branch = 0;
            if (ex_valid && ex_branch && cyc >= free_at) begin
                if (exp_br < 65535) exp_br++;
                if (ref_taken(funct3, rs1_data, rs2_data)) begin
                    if (exp_tk < 65535) exp_tk++;
                    exp_branch = 1;
                    exp_target = pc + imm;
                    free_at    = cyc + SL + 1;
                end
            end
        end
        exp_shadow = (cyc + 1 < free_at);
        cyc++;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("branch", {63'd0, branch}, {63'd0, exp_branch});
            chk("target_pc", target_pc, exp_target);
            chk("in_shadow", {63'd0, in_shadow}, {63'd0, exp_shadow});
`ifdef BRANCH_RESOLVE_STATS_EN
            chk("br_count", {48'd0, br_count}, XLEN'(exp_br));
            chk("taken_count", {48'd0, taken_count}, XLEN'(exp_tk));
`endif
        end
    end

    // Drive one cycle of inputs and advance to 1 time unit after the next rising edge.
    task automatic drive(input bit v, input bit b, input logic [2:0] f3, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] bb, input logic [XLEN-1:0] p, input logic [XLEN-1:0] i);
        ex_valid = v; ex_branch = b; funct3 = f3;
        rs1_data = a; rs2_data = bb; pc = p; imm = i;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 3'b000, '0, '0, '0, '0);
    endtask

    logic [XLEN-1:0] ops_a [4];
    logic [XLEN-1:0] ops_b [4];

    initial begin
        reset = 1;
        idle();
        started = 1;
        idle();
        idle();
        chk("reset_branch", {63'd0, branch}, 64'd0);
        chk("reset_target", target_pc, 64'd0);
        chk("reset_shadow", {63'd0, in_shadow}, 64'd0);
        reset = 0;
        idle();

        // BEQ taken
        drive(1, 1, 3'b000, 64'd5, 64'd5, 64'h100, 64'h20);
        chk("beq_branch", {63'd0, branch}, 64'd1);
        chk("beq_target", target_pc, 64'h120);
        idle();
        chk("beq_pulse_end", {63'd0, branch}, 64'd0);
        chk("beq_shadow", {63'd0, in_shadow}, 64'd1);
        idle();

        // BLT taken vs BLTU not taken
        drive(1, 1, 3'b100, '1, 64'd1, 64'h400, 64'h40);
        chk("blt_branch", {63'd0, branch}, 64'd1);
        idle(); idle();
        drive(1, 1, 3'b110, '1, 64'd1, 64'h500, 64'h40);
        chk("bltu_branch", {63'd0, branch}, 64'd0);
        chk("bltu_target_hold", target_pc, 64'h440);
        idle();

        // Shadow suppression and back-to-back spacing
        drive(1, 1, 3'b000, 64'd1, 64'd1, 64'h200, 64'h8);
        chk("sh_first", target_pc, 64'h208);
        drive(1, 1, 3'b000, 64'd2, 64'd2, 64'h600, 64'h8);
        chk("sh_n2_branch", {63'd0, branch}, 64'd0);
        drive(1, 1, 3'b000, 64'd2, 64'd2, 64'h600, 64'h8);
        chk("sh_n3_branch", {63'd0, branch}, 64'd0);
        drive(1, 1, 3'b000, 64'd3, 64'd3, 64'h300, 64'h10);
        chk("sh_n4_branch", {63'd0, branch}, 64'd1);
        chk("sh_n4_target", target_pc, 64'h310);
        idle(); idle();

        // Wrap-around target
        drive(1, 1, 3'b001, 64'd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20);
        chk("wrap_target", target_pc, 64'h10);
        idle(); idle();

        // Non-evaluating and never-taken encodings
        drive(0, 1, 3'b000, 64'd7, 64'd7, 64'h10, 64'h10);
        drive(1, 0, 3'b000, 64'd7, 64'd7, 64'h10, 64'h10);
        drive(1, 1, 3'b010, 64'd7, 64'd7, 64'h10, 64'h10);
        drive(1, 1, 3'b011, 64'd7, 64'd8, 64'h10, 64'h10);
        chk("f3_011_branch", {63'd0, branch}, 64'd0);
        chk("no_eval_shadow", {63'd0, in_shadow}, 64'd0);

        // Sweep every condition over a few operand pairs
        ops_a[0] = '1;        ops_b[0] = 64'd1;
        ops_a[1] = 64'd1;     ops_b[1] = '1;
        ops_a[2] = 64'd9;     ops_b[2] = 64'd9;
        ops_a[3] = 64'h8000_0000_0000_0000; ops_b[3] = 64'h7FFF_FFFF_FFFF_FFFF;
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < 4; k++) begin
                drive(1, 1, 3'(f), ops_a[k], ops_b[k], 64'h1000 + 64'(k * 16), 64'(f * 4));
                idle(); idle();
            end
        end

        // Reset during the pulse aborts the shadow
        drive(1, 1, 3'b111, 64'd3, 64'd3, 64'h700, 64'h4);
        chk("rst_pre_branch", {63'd0, branch}, 64'd1);
        reset = 1;
        idle();
        chk("rst_shadow", {63'd0, in_shadow}, 64'd0);
        chk("rst_target", target_pc, 64'd0);
        reset = 0;
        drive(1, 1, 3'b101, 64'd4, 64'd3, 64'h800, 64'h8);
        chk("rst_after_branch", {63'd0, branch}, 64'd1);
        chk("rst_after_target", target_pc, 64'h808);
        idle(); idle();

        // Reset coinciding with a taken evaluation
        reset = 1;
        drive(1, 1, 3'b000, 64'd1, 64'd1, 64'h900, 64'h8);
        chk("rst_same_branch", {63'd0, branch}, 64'd0);
        reset = 0;
        idle();

`ifdef BRANCH_RESOLVE_STATS_EN
        reset = 1;
        idle();
        reset = 0;
        drive(1, 1, 3'b000, 64'd1, 64'd1, 64'h10, 64'h4);
        idle(); idle();
        drive(1, 1, 3'b001, 64'd1, 64'd2, 64'h10, 64'h4);
        idle(); idle();
        drive(1, 1, 3'b010, 64'd1, 64'd1, 64'h10, 64'h4);
        chk("stats_br", {48'd0, br_count}, 64'd3);
        chk("stats_taken", {48'd0, taken_count}, 64'd2);
        idle();
`endif

        idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
